freq_meter: RTL and testbench

Gated frequency and duty-cycle meter that consumes a divided clock (e.g. the divide-by-5 output) as a plain data signal and measures it against the system clock. It counts rising edges and high-level samples over a programmable window of `clk` cycles, then reports both results with a one-cycle valid strobe. It sits directly downstream of the clock-divider stage and is used for on-chip ratio and duty checks.

---
 rtl/freq_meter.sv | 132 +++++++++++++
 tb/tb_freq_meter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Gated frequency and duty-cycle meter: counts rising edges and high samples of an
// asynchronous input over a programmable window of clk cycles, then strobes valid.
module freq_meter #(
    parameter  int GATE_CYCLES = 1000,
    parameter  int CNT_W       = 16,
    parameter  int SYNC_STAGES = 2,
    localparam int HIGH_W      = $clog2(GATE_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sig_in,
    input  logic              start,
    input  logic              continuous,
    input  logic              abort,
    output logic [CNT_W-1:0]  count,
    output logic [HIGH_W-1:0] high_time,
    output logic              overflow,
    output logic              valid,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

    state_t                   state;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     sig_s;
    logic                     sig_d;
    logic                     rise;
    logic [HIGH_W-1:0]        gate_cnt;
    logic [HIGH_W-1:0]        high_cnt;
    logic [HIGH_W-1:0]        high_nxt;
    logic [CNT_W-1:0]         edge_cnt;
    logic [CNT_W-1:0]         edge_nxt;
    logic                     ovf;
    logic                     ovf_nxt;

    assign sig_s = sync_q[SYNC_STAGES-1];
    assign rise  = sig_s & ~sig_d;

    // Free-running synchronizer so an edge right at window start is already visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            sig_d  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge
            // value, which is what turns this into a real shift chain.
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            sig_d  <= sig_s;
        end
    end

    // Counter values including the current cycle's sample; used both for the
    // running count and for the result load on the final gate cycle.
    always_comb begin
        // NOTE: defaults first, so no path leaves a variable unassigned (no latch).
        edge_nxt = edge_cnt;
        ovf_nxt  = ovf;
        high_nxt = high_cnt;
        if (rise) begin
            if (&edge_cnt) ovf_nxt = 1'b1;
            else           edge_nxt = edge_cnt + CNT_W'(1);
        end
        if (sig_s) high_nxt = high_cnt + HIGH_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gate_cnt  <= '0;
            edge_cnt  <= '0;
            high_cnt  <= '0;
            ovf       <= 1'b0;
            count     <= '0;
            high_time <= '0;
            overflow  <= 1'b0;
            valid     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid <= 1'b0;
                    if (start | continuous) begin
                        state    <= GATE;
                        busy     <= 1'b1;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        high_cnt <= '0;
                        ovf      <= 1'b0;
                    end
                end
                GATE: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gate_cnt <= gate_cnt + HIGH_W'(1);
                        edge_cnt <= edge_nxt;
                        high_cnt <= high_nxt;
                        ovf      <= ovf_nxt;
                        if (gate_cnt == HIGH_W'(GATE_CYCLES - 1)) begin
                            state     <= DONE;
                            valid     <= 1'b1;
                            count     <= edge_nxt;
                            high_time <= high_nxt;
                            overflow  <= ovf_nxt;
                        end
                    end
                end
                DONE: begin
                    valid    <= 1'b0;
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    high_cnt <= '0;
                    ovf      <= 1'b0;
                    if (continuous) begin
                        state <= GATE;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: randomized and patterned inputs compared
// against a window model computed from the recorded input history.
module tb_freq_meter;

    localparam int G   = 1000;
    localparam int G2  = 100;
    localparam int S   = 2;
    localparam int HW  = $clog2(G + 1);
    localparam int HW2 = $clog2(G2 + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          sig_in = 1'b0, start = 1'b0, continuous = 1'b0, abort = 1'b0;
    logic [15:0]   count;
    logic [HW-1:0] high_time;
    logic          overflow, valid, busy;

    logic           sig_in2 = 1'b0, start2 = 1'b0, cont2 = 1'b0, abort2 = 1'b0;
    logic [3:0]     count2;
    logic [HW2-1:0] high2;
    logic           ovf2, valid2, busy2;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(16), .SYNC_STAGES(S)) u_dut (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start),
        .continuous(continuous), .abort(abort), .count(count),
        .high_time(high_time), .overflow(overflow), .valid(valid), .busy(busy)
    );

    freq_meter #(.GATE_CYCLES(G2), .CNT_W(4), .SYNC_STAGES(S)) u_ovf (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in2), .start(start2),
        .continuous(cont2), .abort(abort2), .count(count2),
        .high_time(high2), .overflow(ovf2), .valid(valid2), .busy(busy2)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit samp [4096];
    bit samp2 [4096];

    typedef enum {M_CONST, M_TOGGLE, M_DIV5, M_RAND} mode_e;
    mode_e mode = M_CONST;
    int    half = 5;
    int    ph = 0;
    int    ph2 = 0;
    bit    tog2 = 1'b0;

    // Input waveforms change only on the falling edge.
    always @(negedge clk) begin
        case (mode)
            M_CONST:  sig_in = 1'b0;
            M_TOGGLE: if (ph >= half - 1) begin ph = 0; sig_in = ~sig_in; end else ph++;
            M_DIV5:   begin ph = (ph >= 4) ? 0 : ph + 1; sig_in = (ph < 2); end
            default:  sig_in = 1'($urandom_range(0, 1));
        endcase
        if (tog2) begin
            if (ph2 >= 1) begin ph2 = 0; sig_in2 = ~sig_in2; end else ph2++;
        end else begin
            sig_in2 = 1'b0;
        end
    end

    // Edge k records the input value sampled by the design at that edge.
    always @(posedge clk) begin
        samp[cyc % 4096]  = sig_in;
        samp2[cyc % 4096] = sig_in2;
        cyc++;
    end

    // A window closed at edge v samples edges v-g+1..v; the synchronized level
    // seen at edge k is the input sampled S edges earlier.
    function automatic void model(input int v, input int g, input bit which, input int cmax,
                                  output int ecnt, output int ehigh, output bit eovf);
        int rises;
        bit cur, prv;
        rises = 0;
        ehigh = 0;
        for (int k = v - g + 1; k <= v; k++) begin
            cur = which ? samp2[(k - S) % 4096] : samp[(k - S) % 4096];
            prv = which ? samp2[(k - S - 1) % 4096] : samp[(k - S - 1) % 4096];
            ehigh += int'(cur);
            if (cur && !prv) rises++;
        end
        ecnt = (rises > cmax) ? cmax : rises;
        eovf = (rises > cmax);
    endfunction

    task automatic wait_valid(input bit which, input int budget, output int v);
        bit ok;
        ok = 1'b0;
        v = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((which ? valid2 : valid) === 1'b1) begin
                v = cyc - 1;
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL valid_timeout: valid not seen within %0d cycles, required a strobe", budget);
        end
    endtask

    task automatic pulse_start(output int e);
        @(negedge clk);
        start = 1'b1;
        e = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        bit seen;
        rst_n = 1'b0;
        mode = M_RAND;
        tog2 = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", count); end
        checks++; if (high_time !== '0) begin errors++; $display("FAIL reset_high: got %0d required 0", high_time); end
        checks++; if ({overflow, valid, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b required 000", {overflow, valid, busy}); end
        checks++; if ({count2, ovf2, valid2, busy2} !== 7'd0) begin errors++; $display("FAIL reset_ovf_inst: got %b required 0", {count2, ovf2, valid2, busy2}); end
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (valid || busy || valid2 || busy2) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_idle: valid/busy seen=%0d required 0", seen); end
    endtask

    task automatic test_basic();
        int e, v, ec, eh;
        bit eo;
        mode = M_TOGGLE;
        half = 5;
        ph = 0;
        repeat (20) @(negedge clk);
        pulse_start(e);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b required 1", busy); end
        wait_valid(1'b0, G + 10, v);
        model(v, G, 1'b0, 65535, ec, eh, eo);
        checks++; if (v !== e + G) begin errors++; $display("FAIL basic_latency: valid at edge %0d required %0d", v, e + G); end
        checks++; if (count !== 16'd100 || count !== 16'(ec)) begin errors++; $display("FAIL basic_count: got %0d required 100 (model %0d)", count, ec); end
        checks++; if (high_time !== HW'(500) || high_time !== HW'(eh)) begin errors++; $display("FAIL basic_high: got %0d required 500 (model %0d)", high_time, eh); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b required 0", overflow); end
        @(negedge clk);
        checks++; if ({valid, busy} !== 2'b00) begin errors++; $display("FAIL basic_after: valid,busy=%b required 00", {valid, busy}); end
    endtask

    task automatic test_divider();
        int e, v, prev_v, first_high, ec, eh;
        bit eo;
        mode = M_DIV5;
        ph = 0;
        repeat (10) @(negedge clk);
        @(negedge clk);
        continuous = 1'b1;
        e = cyc;
        prev_v = 0;
        first_high = 0;
        for (int w = 0; w < 3; w++) begin
            wait_valid(1'b0, G + 10, v);
            model(v, G, 1'b0, 65535, ec, eh, eo);
            checks++;
            if (v !== ((w == 0) ? e + G : prev_v + G + 1)) begin
                errors++; $display("FAIL div_period: window %0d valid at edge %0d (prev %0d, start %0d)", w, v, prev_v, e);
            end
            checks++; if (count !== 16'd200 || count !== 16'(ec)) begin errors++; $display("FAIL div_count: window %0d got %0d required 200 (model %0d)", w, count, ec); end
            if (w == 0) first_high = int'(high_time);
            checks++;
            if (!(high_time == HW'(400) || high_time == HW'(600)) || high_time !== HW'(first_high) || high_time !== HW'(eh)) begin
                errors++; $display("FAIL div_high: window %0d got %0d required %0d in {400,600} (model %0d)", w, high_time, first_high, eh);
            end
            prev_v = v;
            @(negedge clk);
            if (w == 1) continuous = 1'b0;
        end
        checks++; if ({valid, busy} !== 2'b00) begin errors++; $display("FAIL div_stop: valid,busy=%b required 00", {valid, busy}); end
    endtask

    task automatic test_overflow();
        int e, v, ec, eh;
        bit eo;
        tog2 = 1'b1;
        @(negedge clk);
        start2 = 1'b1;
        e = cyc;
        @(negedge clk);
        start2 = 1'b0;
        wait_valid(1'b1, G2 + 10, v);
        model(v, G2, 1'b1, 15, ec, eh, eo);
        checks++; if (v !== e + G2) begin errors++; $display("FAIL ovf_latency: valid at edge %0d required %0d", v, e + G2); end
        checks++; if (count2 !== 4'd15 || ovf2 !== 1'b1 || ec != 15 || !eo) begin errors++; $display("FAIL ovf_sat: count=%0d ovf=%b required 15/1", count2, ovf2); end
        checks++; if (high2 !== HW2'(eh)) begin errors++; $display("FAIL ovf_high: got %0d required %0d", high2, eh); end
        tog2 = 1'b0;
        repeat (8) @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        wait_valid(1'b1, G2 + 10, v);
        checks++; if (count2 !== 4'd0 || ovf2 !== 1'b0 || high2 !== '0) begin errors++; $display("FAIL ovf_quiet: count=%0d ovf=%b high=%0d required 0/0/0", count2, ovf2, high2); end
    endtask

    task automatic test_abort();
        int e, v, ec, eh;
        bit eo, seen;
        logic [15:0] pc;
        logic [HW-1:0] phh;
        logic po;
        mode = M_RAND;
        pc = count; phh = high_time; po = overflow;
        pulse_start(e);
        while (cyc < e + 500) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if ({valid, busy} !== 2'b00) begin errors++; $display("FAIL abort_busy: valid,busy=%b required 00", {valid, busy}); end
        seen = 1'b0;
        repeat (600) begin
            @(negedge clk);
            if (valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_valid: strobe seen=%0d required 0", seen); end
        checks++; if (count !== pc || high_time !== phh || overflow !== po) begin errors++; $display("FAIL abort_hold: got %0d/%0d/%b required %0d/%0d/%b", count, high_time, overflow, pc, phh, po); end
        pulse_start(e);
        wait_valid(1'b0, G + 10, v);
        model(v, G, 1'b0, 65535, ec, eh, eo);
        checks++; if (v !== e + G) begin errors++; $display("FAIL abort_restart_latency: valid at %0d required %0d", v, e + G); end
        checks++; if (count !== 16'(ec) || high_time !== HW'(eh) || overflow !== eo) begin errors++; $display("FAIL abort_restart: got %0d/%0d/%b required %0d/%0d/%b", count, high_time, overflow, ec, eh, eo); end
    endtask

    task automatic test_start_in_gate();
        int e, v, ec, eh;
        bit eo;
        mode = M_RAND;
        pulse_start(e);
        while (cyc < e + 300) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid(1'b0, G + 10, v);
        model(v, G, 1'b0, 65535, ec, eh, eo);
        checks++; if (v !== e + G) begin errors++; $display("FAIL restart_ignored: valid at %0d required %0d", v, e + G); end
        checks++; if (count !== 16'(ec) || high_time !== HW'(eh)) begin errors++; $display("FAIL restart_result: got %0d/%0d required %0d/%0d", count, high_time, ec, eh); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL restart_idle: busy=%b required 0", busy); end
    endtask

    task automatic test_abort_last();
        int e;
        bit seen;
        logic [15:0] pc;
        logic [HW-1:0] phh;
        pc = count; phh = high_time;
        pulse_start(e);
        while (cyc < e + G) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        seen = (valid !== 1'b0) || (busy !== 1'b0);
        repeat (20) begin
            @(negedge clk);
            if (valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_last: valid/busy seen=%0d required 0", seen); end
        checks++; if (count !== pc || high_time !== phh) begin errors++; $display("FAIL abort_last_hold: got %0d/%0d required %0d/%0d", count, high_time, pc, phh); end
    endtask

    task automatic test_reset_mid();
        int e;
        bit seen;
        pulse_start(e);
        while (cyc < e + 400) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (count !== 16'd0 || high_time !== '0 || {overflow, valid, busy} !== 3'b000) begin errors++; $display("FAIL midreset_clear: got %0d/%0d/%b required 0", count, high_time, {overflow, valid, busy}); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (G + 100) begin
            @(negedge clk);
            if (valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_stale: valid/busy seen=%0d required 0", seen); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_divider();
        test_overflow();
        test_abort();
        test_start_in_gate();
        test_abort_last();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
